// File: rtl/opsel_pkg.sv
// Shared select-code, extension-mode and entry definitions for the ALU operand-A selector.
package opsel_pkg;

    localparam int unsigned SEL_SRC_BASE = 0;
    localparam logic        EXT_ZERO     = 1'b0;
    localparam logic        EXT_SIGN     = 1'b1;
    localparam int unsigned OPSEL_DATA_W = 32;

    typedef struct packed {
        logic [OPSEL_DATA_W-1:0] data;
        logic                    err;
        logic                    valid;
    } opsel_entry_t;

    // The immediate code sits directly after the last full-width source.
    function automatic int unsigned sel_imm(input int unsigned num_src);
        return SEL_SRC_BASE + num_src;
    endfunction

endpackage

// File: rtl/opsel_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: 1-cycle latency, 1 beat/cycle.
// in_rdy_o is registered (!skid valid); optional stall counter under ALU_OPSEL_STALL_CNT_EN.
module opsel_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_vld_i,
    output logic         in_rdy_o,
    input  logic [W-1:0] in_dat_i,
    output logic         out_vld_o,
    input  logic         out_rdy_i,
    output logic [W-1:0] out_dat_o
`ifdef ALU_OPSEL_STALL_CNT_EN
    ,
    output logic [15:0]  stall_cnt_o
`endif
);

    logic         main_vld_q, main_vld_d;
    logic [W-1:0] main_dat_q, main_dat_d;
    logic         skid_vld_q, skid_vld_d;
    logic [W-1:0] skid_dat_q, skid_dat_d;
    logic         accept;
    logic         xfer;

    assign in_rdy_o  = ~skid_vld_q;
    assign out_vld_o = main_vld_q;
    assign out_dat_o = main_dat_q;
    assign accept    = in_vld_i & ~skid_vld_q;
    assign xfer      = main_vld_q & out_rdy_i;

    always_comb begin
        main_vld_d = main_vld_q;
        main_dat_d = main_dat_q;
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;
        if (skid_vld_q) begin
            // A full skid blocks acceptance, so only a drain can happen here.
            if (xfer) begin
                main_dat_d = skid_dat_q;
                skid_vld_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_vld_q || xfer) begin
                main_vld_d = 1'b1;
                main_dat_d = in_dat_i;
            end else begin
                skid_vld_d = 1'b1;
                skid_dat_d = in_dat_i;
            end
        end else if (xfer) begin
            main_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            main_vld_q <= 1'b0;
            main_dat_q <= '0;
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
        end else begin
            main_vld_q <= main_vld_d;
            main_dat_q <= main_dat_d;
            skid_vld_q <= skid_vld_d;
            skid_dat_q <= skid_dat_d;
        end
    end

`ifdef ALU_OPSEL_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_vld_q && !out_rdy_i && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: rtl/alu_operand_sel_pipe.sv
// ALU operand-A selector: N sources / extended immediate / illegal-code flag, registered through a skid buffer.
// 1-cycle latency, full rate, in_ready is registered; stall_cnt port exists only with ALU_OPSEL_STALL_CNT_EN.
module alu_operand_sel_pipe
    import opsel_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NUM_SRC = 4,
    parameter int IMM_W   = 5,
    parameter int SEL_W   = $clog2(NUM_SRC + 2)
) (
    input  logic                      CLK,
    input  logic                      Reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEL_W-1:0]          sel,
    input  logic [NUM_SRC*DATA_W-1:0] src,
    input  logic [IMM_W-1:0]          imm,
    input  logic                      imm_sext,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_sel_err
`ifdef ALU_OPSEL_STALL_CNT_EN
    ,
    output logic [15:0]               stall_cnt
`endif
);

    localparam logic [SEL_W-1:0] SEL_IMM_C = SEL_W'(sel_imm(NUM_SRC));

    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] sel_dat;
    logic              sel_err;
    logic [DATA_W:0]   out_pay;

    generate
        if (IMM_W == DATA_W) begin : g_imm_full
            assign imm_ext = imm;
        end else begin : g_imm_ext
            assign imm_ext = {{(DATA_W-IMM_W){(imm_sext == EXT_SIGN) & imm[IMM_W-1]}}, imm};
        end
    endgenerate

    // Anything not matched below is an illegal code: zero data, error flagged.
    always_comb begin
        sel_dat = '0;
        sel_err = 1'b1;
        if (sel == SEL_IMM_C) begin
            sel_dat = imm_ext;
            sel_err = 1'b0;
        end
        for (int k = 0; k < NUM_SRC; k++) begin
            if (sel == SEL_W'(SEL_SRC_BASE + k)) begin
                sel_dat = src[k*DATA_W +: DATA_W];
                sel_err = 1'b0;
            end
        end
    end

    opsel_skid_buf #(
        .W (DATA_W + 1)
    ) u_skid (
        .clk_i       (CLK),
        .rst_ni      (Reset),
        .in_vld_i    (in_valid),
        .in_rdy_o    (in_ready),
        .in_dat_i    ({sel_err, sel_dat}),
        .out_vld_o   (out_valid),
        .out_rdy_i   (out_ready),
        .out_dat_o   (out_pay)
`ifdef ALU_OPSEL_STALL_CNT_EN
        ,
        .stall_cnt_o (stall_cnt)
`endif
    );

    assign out_sel_err = out_pay[DATA_W];
    assign out_data    = out_pay[DATA_W-1:0];

endmodule

// File: doc/alu_operand_sel_pipe.md
Name: alu_operand_sel_pipe

Overview:
- Parametrised, registered ALU operand-A selector for the pipelined CPU datapath.
- Generalises the 2-way "register vs. zero-extended shift amount" select. Adds:
  - N register/forwarding sources.
  - A narrow immediate with selectable zero/sign extension.
  - Illegal-select detection.
  - A valid/ready skid-buffered output stage so ID/EX stalls propagate without combinational ready paths.
- Sits between the operand-forwarding logic and the ALU input register.

Parameters:
- DATA_W, 32: operand width.
- NUM_SRC, 4: number of full-width sources (min 1).
- IMM_W, 5: immediate width (1 ≤ IMM_W ≤ DATA_W); default covers shamt.
- SEL_W, $clog2(NUM_SRC+2): select width. Encoding space covers all sources, the immediate, and at least one illegal code.

Ports:
- CLK, input, 1: clock; all state updates on rising edge.
- Reset, input, 1: synchronous, active-low reset (asserted when 0, sampled on CLK rising edge).
- in_valid, input, 1: upstream presents an operand request.
- in_ready, output, 1: block can accept a request this cycle.
- sel, input, SEL_W: source select.
- src, input, NUM_SRC*DATA_W: packed sources; src[k] occupies bits [k*DATA_W +: DATA_W].
- imm, input, IMM_W: narrow immediate.
- imm_sext, input, 1: 1 = sign-extend imm, 0 = zero-extend.
- out_valid, output, 1: out_data valid.
- out_ready, input, 1: ALU stage accepts.
- out_data, output, DATA_W: selected operand.
- out_sel_err, output, 1: sel was illegal for this beat.

Behaviour:
- Selection, evaluated at input acceptance:
  - sel < NUM_SRC: data = src[sel].
  - sel == NUM_SRC: data = extended imm. Zero-extend when imm_sext=0; replicate imm[IMM_W-1] into the upper DATA_W-IMM_W bits when imm_sext=1. If IMM_W == DATA_W, no extension.
  - sel > NUM_SRC: data = 0, err = 1.
  - err = 0 for legal sel.
- Accept condition: in_valid && in_ready.
- Transfer condition: out_valid && out_ready.
- Storage: two entries, main (drives outputs) and skid. Each entry holds {data, err, valid}.
- in_ready is a register: in_ready = !skid_valid.
- Latency: accepted beat appears on out_data on the next cycle when main is empty or draining. Throughput is 1 beat/cycle.
- Update rules, per cycle:
  - Accept, main empty or transferring, skid empty: beat loads main.
  - Accept, main full and not transferring: beat loads skid; in_ready drops next cycle.
  - Transfer, skid full: skid moves to main, skid clears, in_ready rises next cycle.
  - Transfer, no accept, skid empty: main_valid clears.
  - Simultaneous accept and transfer with skid empty: new beat replaces main, valid stays 1.
- Ordering is strictly preserved; no beat is dropped or duplicated.
- While out_valid=1 and out_ready=0, out_data and out_sel_err hold stable.
- Reset (Reset=0 at edge), including mid-transfer:
  - out_valid=0, out_data=0, out_sel_err=0, skid cleared, in_ready=1 on the following cycle.
  - In-flight beats are discarded.
- Inputs are not sampled while Reset=0.

Optional Feature:
- Macro: ALU_OPSEL_STALL_CNT_EN.
- When defined:
  - Extra output stall_cnt, 16 bits.
  - Increments each cycle with out_valid=1 && out_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared by reset.
- When undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package opsel_pkg holds:
  - Select-code constants: SEL_SRC_BASE=0, sel_imm(NUM_SRC) function.
  - Extension-mode constants EXT_ZERO=0, EXT_SIGN=1.
  - The entry struct typedef {data, err, valid}.
- One natural sub-module: opsel_skid_buf, a generic 2-entry valid/ready skid buffer parametrised by payload width.
- The top module instantiates opsel_skid_buf and contains only select/extend logic.

Test Plan:
- Legal source select: NUM_SRC=4, src[2]=32'hDEADBEEF, sel=2, in_valid=1, out_ready=1 → next cycle out_valid=1, out_data=32'hDEADBEEF, out_sel_err=0.
- Immediate extension:
  - sel=4, imm=5'b10110, imm_sext=0 → out_data=32'h00000016.
  - Same with imm_sext=1 → out_data=32'hFFFFFFF6.
- Illegal select: sel=6 → out_data=0, out_sel_err=1, beat still delivered with out_valid=1.
- Backpressure:
  - Hold out_ready=0 and present beats A, B, C on consecutive cycles → A held in main, B in skid, in_ready=0 before C is accepted.
  - Release out_ready → outputs A, then B, then C in order, no loss.
- Full-rate streaming: out_ready=1, in_valid=1 for 8 cycles with sel cycling 0..3 → 8 outputs on consecutive cycles, in_ready stays 1.
- Reset mid-stall: main and skid full, drive Reset=0 for one edge → out_valid=0, out_data=0, in_ready=1 next cycle. With ALU_OPSEL_STALL_CNT_EN, stall_cnt=0.
